// File: rtl/fifo72_to_gmii_pkg.sv
// -----------------------------------------------------------------------------
// fifo72_to_gmii_pkg
// Word-layout constants and lane-extraction helpers shared by the
// FIFO-to-GMII serializer.
//
// FIFO word layout (72 bits):
//   [71:64] per-byte enable flags, bit 71 belongs to lane 0
//   [63:0]  eight data bytes, [63:56] is lane 0 (transmitted first)
// -----------------------------------------------------------------------------
package fifo72_to_gmii_pkg;

  localparam int DATA_W     = 64;
  localparam int FLAG_W     = 8;
  localparam int LANES      = 8;
  localparam int WORD_W     = DATA_W + FLAG_W;
  localparam int FLAG_MSB   = 71;
  localparam int FLAG_LSB   = 64;
  localparam int LANE_IDX_W = 3;

  localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(LANES - 1);

  // Data byte of the given lane; lane 0 is the most significant byte.
  function automatic logic [7:0] lane_byte(input logic [DATA_W-1:0]     data,
                                           input logic [LANE_IDX_W-1:0] lane);
    logic [DATA_W-1:0] shifted;
    shifted = data << {lane, 3'b000};
    return shifted[DATA_W-1 -: 8];
  endfunction

  // Enable flag of the given lane; lane 0 is the most significant flag bit.
  function automatic logic lane_flag(input logic [FLAG_W-1:0]     flags,
                                     input logic [LANE_IDX_W-1:0] lane);
    logic [FLAG_W-1:0] shifted;
    shifted = flags << lane;
    return shifted[FLAG_W-1];
  endfunction

endpackage : fifo72_to_gmii_pkg

// File: rtl/fifo72_to_gmii.sv
// -----------------------------------------------------------------------------
// fifo72_to_gmii
// Drains a show-ahead 72-bit FIFO and emits one byte per gmii_tx_clk onto a
// GMII transmit interface. Each word carries 8 bytes plus 8 per-byte enable
// flags; flags pass straight through to gmii_tx_en, so framing, preamble and
// IFG live entirely in the FIFO contents. Back-to-back words stream with no
// gap (one pop every 8 clocks). On underrun the outputs go idle after the
// current word; the next word always starts at lane 0.
//
// Ports:
//   gmii_tx_clk  in   GMII TX clock, the only clock
//   sys_rst      in   synchronous active-high reset
//   dout[71:0]   in   FIFO show-ahead word (flags [71:64], data [63:0])
//   empty        in   FIFO empty; dout valid when low
//   rd_en        out  FIFO pop (combinational), consumed at the clock edge
//   rd_clk       out  FIFO read clock, equal to gmii_tx_clk
//   gmii_tx_en   out  GMII transmit enable (registered)
//   gmii_txd     out  GMII transmit data (registered)
// -----------------------------------------------------------------------------
module fifo72_to_gmii
  import fifo72_to_gmii_pkg::*;
(
  input  logic              gmii_tx_clk,
  input  logic              sys_rst,
  input  logic [WORD_W-1:0] dout,
  input  logic              empty,
  output logic              rd_en,
  output logic              rd_clk,
  output logic              gmii_tx_en,
  output logic [7:0]        gmii_txd
);

  logic [DATA_W-1:0]     data_q, data_d;
  logic [FLAG_W-1:0]     flag_q, flag_d;
  logic [LANE_IDX_W-1:0] cnt_q,  cnt_d;
  logic                  busy_q, busy_d;   // data_q still holds unsent bytes
  logic                  tx_en_q, tx_en_d;
  logic [7:0]            txd_q,  txd_d;

  assign rd_clk = gmii_tx_clk;

  // Pop when idle, or while the last lane goes out so the next word follows
  // without a gap. Reset masks the pop so reset never consumes a word.
  assign rd_en = !sys_rst && !empty && (!busy_q || (cnt_q == LAST_LANE));

  // NOTE: combinational next-state uses blocking '=' with a default for every
  // variable first, so no latch is inferred; the register block below uses
  // only non-blocking '<='.
  always_comb begin
    data_d  = data_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    tx_en_d = 1'b0;
    txd_d   = 8'h00;

    if (busy_q) begin
      txd_d   = lane_byte(data_q, cnt_q);
      tx_en_d = lane_flag(flag_q, cnt_q);
      cnt_d   = cnt_q + 1'b1;              // wraps 7 -> 0 naturally
      if (cnt_q == LAST_LANE) begin
        busy_d = 1'b0;                     // overridden below if a load follows
      end
    end

    // A load may coincide with the last lane going out.
    if (rd_en) begin
      data_d = dout[DATA_W-1:0];
      flag_d = dout[FLAG_MSB:FLAG_LSB];
      cnt_d  = '0;
      busy_d = 1'b1;
    end
  end

  // NOTE: the word register is only 72 flops, not a memory array, so it is
  // cleared by reset along with the control state; a reset mid-word simply
  // abandons the remaining bytes.
  always_ff @(posedge gmii_tx_clk) begin
    if (sys_rst) begin
      data_q  <= '0;
      flag_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      tx_en_q <= 1'b0;
      txd_q   <= 8'h00;
    end else begin
      data_q  <= data_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      tx_en_q <= tx_en_d;
      txd_q   <= txd_d;
    end
  end

  assign gmii_tx_en = tx_en_q;
  assign gmii_txd   = txd_q;

endmodule : fifo72_to_gmii

// File: tb/tb_fifo72_to_gmii.sv
// -----------------------------------------------------------------------------
// tb_fifo72_to_gmii
// Directed bench for fifo72_to_gmii. A queue stands in for the show-ahead
// FIFO; inputs change just after the rising edge and outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_fifo72_to_gmii;

  logic        clk;
  logic        sys_rst;
  logic [71:0] dout;
  logic        empty;
  logic        rd_en;
  logic        rd_clk;
  logic        gmii_tx_en;
  logic [7:0]  gmii_txd;

  logic [71:0] fifo_q[$];
  int          pops;
  int          n_cmp;
  int          n_err;

  fifo72_to_gmii dut (
    .gmii_tx_clk (clk),
    .sys_rst     (sys_rst),
    .dout        (dout),
    .empty       (empty),
    .rd_en       (rd_en),
    .rd_clk      (rd_clk),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_txd    (gmii_txd)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present the head of the FIFO model on dout/empty.
  task automatic drive_fifo();
    empty = (fifo_q.size() == 0);
    dout  = empty ? 72'h0 : fifo_q[0];
  endtask

  task automatic settle();
    drive_fifo();
    #1;
  endtask

  // One clock: pop the model if rd_en was high into the edge, end on negedge.
  task automatic tick();
    logic popped;
    settle();
    popped = rd_en;
    @(posedge clk);
    #1;
    if (popped) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    drive_fifo();
    @(negedge clk);
  endtask

  task automatic step_out(input string tag, input logic en, input logic [7:0] txd);
    tick();
    check(tag, {7'b0, gmii_tx_en, gmii_txd}, {7'b0, en, txd});
  endtask

  initial begin
    logic [71:0] stream_w [3];
    logic [7:0]  single_b [8];
    logic [7:0]  part_b   [8];
    logic [71:0] w;

    single_b = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    part_b   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h01, 8'h02};
    stream_w[0] = 72'hFF_55555555555555D5;
    stream_w[1] = 72'hFF_0102030405060708;
    stream_w[2] = 72'hFF_1112131415161718;

    n_cmp   = 0;
    n_err   = 0;
    pops    = 0;
    sys_rst = 1'b1;
    empty   = 1'b1;
    dout    = '0;
    @(negedge clk);

    // ---- Reset with a word waiting: no pop, outputs idle
    fifo_q.push_back(72'hFF_0011223344556677);
    for (int i = 0; i < 2; i++) begin
      settle();
      check($sformatf("rst_rd_en%0d", i), {15'b0, rd_en}, 16'h0);
      step_out($sformatf("rst_out%0d", i), 1'b0, 8'h00);
    end
    check("rst_pops", 16'(pops), 16'd0);

    // ---- Single word
    sys_rst = 1'b0;
    settle();
    check("single_rd_en", {15'b0, rd_en}, 16'h1);
    check("single_rd_clk_lo", {15'b0, rd_clk}, {15'b0, clk});
    step_out("single_pop_edge", 1'b0, 8'h00);
    check("single_pops", 16'(pops), 16'd1);
    for (int k = 0; k < 8; k++) begin
      step_out($sformatf("single_l%0d", k), 1'b1, single_b[k]);
    end
    step_out("single_idle0", 1'b0, 8'h00);
    step_out("single_idle1", 1'b0, 8'h00);
    check("single_pops_end", 16'(pops), 16'd1);

    // ---- Streaming: three words, 24 contiguous bytes, pop every 8th clock
    for (int i = 0; i < 3; i++) fifo_q.push_back(stream_w[i]);
    step_out("stream_pop_edge", 1'b0, 8'h00);
    for (int n = 0; n < 3; n++) begin
      w = stream_w[n];
      for (int k = 0; k < 8; k++) begin
        settle();
        check($sformatf("stream_w%0d_rd_en%0d", n, k), {15'b0, rd_en},
              {15'b0, (k == 7) && (n < 2)});
        step_out($sformatf("stream_w%0d_l%0d", n, k), 1'b1, w[63 - 8*k -: 8]);
      end
    end
    step_out("stream_idle", 1'b0, 8'h00);
    check("stream_pops", 16'(pops), 16'd4);

    // ---- Partial flags F0: lanes 0-3 enabled, 4-7 still carry data
    fifo_q.push_back(72'hF0_AABBCCDDEEFF0102);
    step_out("part_pop_edge", 1'b0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      step_out($sformatf("part_l%0d", k), k < 4, part_b[k]);
    end
    step_out("part_idle", 1'b0, 8'h00);

    // ---- Underrun: FIFO runs dry after a word; idle until refilled
    fifo_q.push_back(72'hFF_A0A1A2A3A4A5A6A7);
    step_out("urun_pop_edge", 1'b0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      step_out($sformatf("urun_a_l%0d", k), 1'b1, 8'hA0 + 8'(k));
    end
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("urun_rd_en%0d", i), {15'b0, rd_en}, 16'h0);
      step_out($sformatf("urun_idle%0d", i), 1'b0, 8'h00);
    end
    fifo_q.push_back(72'hFF_B0B1B2B3B4B5B6B7);
    step_out("urun_resume_edge", 1'b0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      step_out($sformatf("urun_b_l%0d", k), 1'b1, 8'hB0 + 8'(k));
    end
    step_out("urun_idle_end", 1'b0, 8'h00);
    check("urun_pops", 16'(pops), 16'd7);

    // ---- Reset mid-word: lane 4 on outputs, then reset discards the rest
    fifo_q.push_back(72'hFF_C0C1C2C3C4C5C6C7);
    fifo_q.push_back(72'hFF_D0D1D2D3D4D5D6D7);
    step_out("mrst_pop_edge", 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      step_out($sformatf("mrst_c_l%0d", k), 1'b1, 8'hC0 + 8'(k));
    end
    sys_rst = 1'b1;
    settle();
    check("mrst_rd_en_in_rst", {15'b0, rd_en}, 16'h0);
    step_out("mrst_rst_edge", 1'b0, 8'h00);
    check("mrst_pops_in_rst", 16'(pops), 16'd8);
    sys_rst = 1'b0;
    settle();
    check("mrst_rd_en_release", {15'b0, rd_en}, 16'h1);
    step_out("mrst_pop2_edge", 1'b0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      step_out($sformatf("mrst_d_l%0d", k), 1'b1, 8'hD0 + 8'(k));
    end
    step_out("mrst_idle", 1'b0, 8'h00);
    check("mrst_pops", 16'(pops), 16'd9);
    check("final_fifo_empty", 16'(fifo_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fifo72_to_gmii

// File: doc/fifo72_to_gmii.md
Name: fifo72_to_gmii

Overview:
- Transmit-side serializer: drains a show-ahead (first-word-fall-through) 72-bit FIFO and emits one byte per clock onto a GMII transmit interface.
- Each FIFO word holds 8 data bytes plus 8 per-byte enable flags.
- Sits between the TX packet FIFO and the PHY. It runs entirely in the GMII TX clock domain and drives the FIFO read clock from that clock.

Parameters:
- none. Widths are fixed: 72-bit FIFO word, 8-bit GMII.

Ports:
- gmii_tx_clk  input  1  125 MHz GMII TX clock; the only clock.
- sys_rst  input  1  synchronous, active-high reset.
- dout  input  72  FIFO show-ahead data. [71:64] = byte-enable flags, [63:0] = 8 data bytes.
- empty  input  1  FIFO empty; dout is valid when low.
- rd_en  output  1  FIFO pop, combinational; the word on dout is consumed at the gmii_tx_clk edge where rd_en=1.
- rd_clk  output  1  FIFO read clock, wired directly to gmii_tx_clk.
- gmii_tx_en  output  1  GMII transmit enable, registered.
- gmii_txd  output  8  GMII transmit data, registered.

Behaviour:
- Word format: lane k (k=0..7) is data dout[63-8k:56-8k] with flag dout[71-k]. Lane 0 ([63:56], flag bit 71) is transmitted first.
- Internal state:
  - word register data_r[63:0] and flag register flag_r[7:0];
  - byte counter cnt[2:0];
  - busy flag, meaning data_r holds an unsent word.
- rd_en = !sys_rst && !empty && (!busy || cnt==7). Pure combinational; no dependence on the outputs.
- At an edge with rd_en=1: data_r<=dout[63:0], flag_r<=dout[71:64], cnt<=0, busy<=1.
- At an edge with busy=1:
  - gmii_txd<=lane[cnt] of data_r, gmii_tx_en<=flag of lane[cnt];
  - cnt<=cnt+1, wrapping 7->0.
  - If cnt==7 and no load occurs (empty=1), busy<=0.
- At an edge with busy=0: gmii_tx_en<=0, gmii_txd<=0.
- Load and last-byte output in the same edge are legal. Back-to-back words therefore stream with no idle cycle: 8 bytes per word, one pop every 8 clocks.
- Latency: word popped at edge N; lane 0 is on the outputs after edge N+1; lane 7 after edge N+8.
- Flags are passed through per byte. Frame boundaries, preamble/SFD and inter-frame gap are carried in the FIFO content as flag-0 bytes; the block does no framing, CRC or IFG insertion.
- Underrun (FIFO empty when the next word is needed): outputs go idle (tx_en=0, txd=0) from the next byte slot. Any partial frame is truncated; no error signalling. Resumes when empty deasserts; the first word after that starts at lane 0.
- Flag-0 bytes still output their data byte on gmii_txd with tx_en=0; the byte slot is not skipped.
- Reset, synchronous, takes priority over everything:
  - busy=0, cnt=0, data_r=0, flag_r=0;
  - gmii_tx_en=0, gmii_txd=0;
  - rd_en=0 combinationally while sys_rst=1.
- Reset mid-word discards the remaining bytes of the current word. Reset never pops the FIFO.

Decomposition:
- Shared package: word-layout constants (data width 64, flag width 8, lane count 8, flag field MSB 71/LSB 64).
- Single module; no sub-module needed. The serializer is one counter plus one word register.

Test Plan:
- Reset: hold sys_rst=1 for 2 clocks with empty=0 -> rd_en=0 throughout; gmii_tx_en=0, gmii_txd=00; FIFO not popped.
- Single word: empty=0, dout=FF_0011223344556677, then empty=1 -> exactly one pop. Bytes 00,11,22,33,44,55,66,77 with tx_en=1 on 8 consecutive clocks starting 2 edges after the pop, then tx_en=0, txd=00.
- Streaming: 3 back-to-back words of all-ones flags (e.g. 55555555555555D5 preamble word, then payload) -> 24 contiguous tx_en=1 cycles; rd_en pulses exactly every 8th clock.
- Partial flags: word flags F0, data AABBCCDDEEFF0102 -> tx_en=1 for AA,BB,CC,DD; tx_en=0 with txd EE,FF,01,02.
- Underrun: empty rises while lane 3 of a word is on the outputs -> lanes 4-7 still sent. Then tx_en=0 until a new word is popped; the new word starts at lane 0.
- Reset mid-word: assert sys_rst while lane 4 is on the outputs -> next edge gives tx_en=0, txd=00. After release the next pop restarts at lane 0 and the interrupted word is not resumed.
